sobel_window_buffer: RTL and testbench

//  Window generator between the grayscale stage (sobel_filter, 10-bit y) and the Sobel gradient stage.
//  - Input: raster-ordered grayscale pixel stream.
//  - Storage: two line buffers plus a 3x3 shift window.
//  - Output: one full 3x3 neighbourhood per interior pixel, under valid/ready flow control.
//  - Border pixels (x or y = 0 or max) never produce a window.

---
 rtl/sobel_pkg.sv | 15 +
 rtl/sobel_line_buffer.sv | 32 +++
 rtl/sobel_window_buffer.sv | 137 +++++++++++++
 tb/tb_sobel_window_buffer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types for the Sobel pipeline: pixel/window widths and window element offsets.
package sobel_pkg;

  localparam int unsigned PIX_W = 10;
  localparam int unsigned WIN_N = 3;

  typedef logic [PIX_W-1:0]   pix_t;
  typedef logic [9*PIX_W-1:0] win_t;

  // Bit offset of window element (r,c); r=0 top (oldest) row, c=0 left (oldest) column.
  function automatic int unsigned win_idx(input int unsigned r, input int unsigned c);
    return PIX_W * (WIN_N * r + c);
  endfunction

endpackage

// File: rtl/sobel_line_buffer.sv
// One line of pixel storage: single write port, asynchronous read port, contents unreset.
//   clk       : clock
//   i_we      : write enable
//   i_waddr   : write address (column)
//   i_wdata   : write data
//   i_raddr   : read address (column)
//   o_rdata_c : combinational read data
module sobel_line_buffer
  import sobel_pkg::*;
#(
  parameter int unsigned DEPTH = 640
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [PIX_W-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [PIX_W-1:0]         o_rdata_c
);

  pix_t r_mem [DEPTH];

  // Storage write; no reset so this maps onto a plain RAM.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_c = r_mem[i_raddr];

endmodule

// File: rtl/sobel_window_buffer.sv
// Turns a raster grayscale stream into 3x3 neighbourhoods, one per interior pixel.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_in_valid   : input pixel valid
//   o_in_ready   : input accepted this cycle (combinational from output handshake)
//   i_in_pixel   : grayscale pixel, raster order
//   i_in_sof     : first pixel of a frame
//   o_out_valid  : window valid
//   i_out_ready  : downstream accepts window
//   o_out_win    : 3x3 window, element (r,c) at win_idx(r,c)
//   o_out_eof    : last window of the frame
module sobel_window_buffer
  import sobel_pkg::*;
#(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  input  logic [PIX_W-1:0]     i_in_pixel,
  input  logic                 i_in_sof,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [9*PIX_W-1:0]   o_out_win,
  output logic                 o_out_eof
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);

  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic          w_acc;
  logic          w_emit;
  logic          w_last_x;
  logic          w_last_y;
  pix_t          w_lb0_rd;
  pix_t          w_lb1_rd;
  pix_t          r_win     [WIN_N][WIN_N];
  pix_t          w_win_nxt [WIN_N][WIN_N];
  win_t          w_win_packed;

  // Single output register: input stalls whenever a held window is not taken.
  assign o_in_ready = ~o_out_valid | i_out_ready;
  assign w_acc      = i_in_valid & o_in_ready;

  // Coordinates of the pixel being offered; sof forces it to (0,0).
  assign w_x      = i_in_sof ? '0 : r_x;
  assign w_y      = i_in_sof ? '0 : r_y;
  assign w_last_x = (w_x == XW'(IMG_W - 1));
  assign w_last_y = (w_y == YW'(IMG_H - 1));
  assign w_emit   = w_acc && (w_x >= XW'(2)) && (w_y >= YW'(2));

  // lb0 holds row y-1, lb1 row y-2; on accept each column ages by one row.
  sobel_line_buffer #(.DEPTH(IMG_W)) u_lb0 (
    .clk       (clk),
    .i_we      (w_acc),
    .i_waddr   (w_x),
    .i_wdata   (i_in_pixel),
    .i_raddr   (w_x),
    .o_rdata_c (w_lb0_rd)
  );

  sobel_line_buffer #(.DEPTH(IMG_W)) u_lb1 (
    .clk       (clk),
    .i_we      (w_acc),
    .i_waddr   (w_x),
    .i_wdata   (w_lb0_rd),
    .i_raddr   (w_x),
    .o_rdata_c (w_lb1_rd)
  );

  // Window after a left shift with the new column {lb1, lb0, pixel} on the right.
  always_comb begin
    w_win_packed = '0;
    for (int unsigned r = 0; r < WIN_N; r++) begin
      w_win_nxt[r][0] = r_win[r][1];
      w_win_nxt[r][1] = r_win[r][2];
    end
    w_win_nxt[0][2] = w_lb1_rd;
    w_win_nxt[1][2] = w_lb0_rd;
    w_win_nxt[2][2] = i_in_pixel;
    for (int unsigned r = 0; r < WIN_N; r++) begin
      for (int unsigned c = 0; c < WIN_N; c++) begin
        w_win_packed[win_idx(r, c) +: PIX_W] = w_win_nxt[r][c];
      end
    end
  end

  // Raster position of the next expected pixel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x <= '0;
      r_y <= '0;
    end else if (w_acc) begin
      if (w_last_x) begin
        r_x <= '0;
        r_y <= w_last_y ? '0 : w_y + YW'(1);
      end else begin
        r_x <= w_x + XW'(1);
        r_y <= w_y;
      end
    end
  end

  // 3x3 shift window; stale columns at line start are flushed before any emit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned r = 0; r < WIN_N; r++) begin
        for (int unsigned c = 0; c < WIN_N; c++) begin
          r_win[r][c] <= '0;
        end
      end
    end else if (w_acc) begin
      r_win <= w_win_nxt;
    end
  end

  // Output register; w_emit implies in_ready, so a held window is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_out_valid <= 1'b0;
      o_out_win   <= '0;
      o_out_eof   <= 1'b0;
    end else if (w_emit) begin
      o_out_valid <= 1'b1;
      o_out_win   <= w_win_packed;
      o_out_eof   <= w_last_x & w_last_y;
    end else if (i_out_ready) begin
      o_out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_window_buffer.sv
module tb_sobel_window_buffer;
  import sobel_pkg::*;

  typedef logic [9*PIX_W:0] exp_t;  // {eof, window}

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic v4, rdy4, sof4, ov4, or4, eof4;
  pix_t pix4;
  win_t win4;
  logic v8, rdy8, sof8, ov8, or8, eof8;
  pix_t pix8;
  win_t win8;

  sobel_window_buffer #(.IMG_W(4), .IMG_H(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(v4), .o_in_ready(rdy4), .i_in_pixel(pix4),
    .i_in_sof(sof4), .o_out_valid(ov4), .i_out_ready(or4), .o_out_win(win4), .o_out_eof(eof4)
  );

  sobel_window_buffer #(.IMG_W(8), .IMG_H(6)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .i_in_valid(v8), .o_in_ready(rdy8), .i_in_pixel(pix8),
    .i_in_sof(sof8), .o_out_valid(ov8), .i_out_ready(or8), .o_out_win(win8), .o_out_eof(eof8)
  );

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q4[$];
  exp_t q8[$];
  int   n_win4 = 0;
  int   n_win8 = 0;
  logic rnd8 = 1'b0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference window from the pixel formula 16*y+x, centred on (cx,cy).
  function automatic exp_t ref_win(input int w, input int h, input int cx, input int cy);
    win_t wv = '0;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        wv[PIX_W*(3*r+c) +: PIX_W] = PIX_W'(16*(cy-1+r) + (cx-1+c));
    return {((cx == w-2) && (cy == h-2)), wv};
  endfunction

  task automatic push_frame(input int which);
    if (which == 4) begin
      for (int cy = 1; cy <= 2; cy++)
        for (int cx = 1; cx <= 2; cx++) q4.push_back(ref_win(4, 4, cx, cy));
    end else begin
      for (int cy = 1; cy <= 4; cy++)
        for (int cx = 1; cx <= 6; cx++) q8.push_back(ref_win(8, 6, cx, cy));
    end
  endtask

  // Transfers happen at the next posedge when valid & ready are seen here.
  always @(negedge clk) begin
    if (rst_n && ov4 && or4) begin
      n_win4++;
      if (q4.size() == 0) check_val("win4_extra", 128'(q4.size()), 128'(1));
      else check_val("win4", 128'({eof4, win4}), 128'(q4.pop_front()));
    end
    if (rst_n && ov8 && or8) begin
      n_win8++;
      if (q8.size() == 0) check_val("win8_extra", 128'(q8.size()), 128'(1));
      else check_val("win8", 128'({eof8, win8}), 128'(q8.pop_front()));
    end
  end

  always @(posedge clk) begin
    if (rnd8) begin
      #1;
      or8 = 1'($urandom_range(1, 0));
    end
  end

  task automatic send4(input int x, input int y, input bit sof);
    int n = 0;
    v4 = 1'b1; pix4 = PIX_W'(16*y + x); sof4 = sof;
    @(negedge clk);
    while (!rdy4 && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) check_val("send4_timeout", 128'(n), 128'(0));
    @(posedge clk); #1;
    sof4 = 1'b0;
  endtask

  task automatic send8(input int x, input int y, input bit sof);
    int n = 0;
    v8 = 1'b1; pix8 = PIX_W'(16*y + x); sof8 = sof;
    @(negedge clk);
    while (!rdy8 && n < 200) begin n++; @(negedge clk); end
    if (n >= 200) check_val("send8_timeout", 128'(n), 128'(0));
    @(posedge clk); #1;
    sof8 = 1'b0;
  endtask

  task automatic send_frame4();
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) send4(x, y, (x == 0 && y == 0));
  endtask

  task automatic drain4(input string tag, input int base, input int want);
    int n = 0;
    v4 = 1'b0;
    while (q4.size() != 0 && n < 300) begin @(posedge clk); n++; end
    repeat (4) @(posedge clk);
    #1;
    check_val({tag, "_drain"}, 128'(q4.size()), 128'(0));
    check_val({tag, "_count"}, 128'(n_win4 - base), 128'(want));
  endtask

  initial begin
    int   base;
    exp_t e17;
    rst_n = 1'b0;
    v4 = 1'b0; pix4 = '0; sof4 = 1'b0; or4 = 1'b1;
    v8 = 1'b0; pix8 = '0; sof8 = 1'b0; or8 = 1'b1;
    e17 = ref_win(4, 4, 1, 1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("rst_out_valid", 128'(ov4), 128'(0));
    check_val("rst_in_ready", 128'(rdy4), 128'(1));
    check_val("rst_out_win", 128'(win4), 128'(0));
    check_val("rst_out_eof", 128'(eof4), 128'(0));
    check_val("rst_out_valid8", 128'(ov8), 128'(0));
    @(posedge clk); #1;

    // Full frame, continuous input.
    base = n_win4;
    push_frame(4);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++) begin
        send4(x, y, (x == 0 && y == 0));
        if (x == 1 && y == 2) check_val("t1_pre_latency", 128'(ov4), 128'(0));
        if (x == 2 && y == 2) check_val("t1_latency", 128'(ov4), 128'(1));
      end
    drain4("t1", base, 4);

    // Backpressure while window 17 is pending.
    base = n_win4;
    push_frame(4);
    or4 = 1'b0;
    for (int p = 0; p <= 10; p++) send4(p % 4, p / 4, (p == 0));
    fork
      begin
        for (int p = 11; p < 16; p++) send4(p % 4, p / 4, 1'b0);
        v4 = 1'b0;
      end
      begin
        repeat (5) begin
          @(negedge clk);
          check_val("t2_in_ready", 128'(rdy4), 128'(0));
          check_val("t2_hold", 128'({eof4, win4}), 128'(e17));
        end
        @(posedge clk); #1 or4 = 1'b1;
      end
    join
    drain4("t2", base, 4);

    // Back-to-back frames.
    base = n_win4;
    push_frame(4);
    push_frame(4);
    send_frame4();
    send_frame4();
    drain4("t3", base, 8);

    // sof at frame-1 pixel (1,2) aborts frame 1.
    base = n_win4;
    for (int p = 0; p <= 8; p++) send4(p % 4, p / 4, (p == 0));
    push_frame(4);
    send_frame4();
    drain4("t4", base, 4);

    // Reset mid-frame right after (3,2) is accepted.
    base = n_win4;
    q4.push_back(e17);
    for (int p = 0; p <= 11; p++) send4(p % 4, p / 4, (p == 0));
    rst_n = 1'b0;
    v4 = 1'b0;
    #1;
    check_val("t5_async_valid", 128'(ov4), 128'(0));
    check_val("t5_async_win", 128'(win4), 128'(0));
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_val("t5_in_ready", 128'(rdy4), 128'(1));
    check_val("t5_out_valid", 128'(ov4), 128'(0));
    @(posedge clk); #1;
    push_frame(4);
    send_frame4();
    drain4("t5", base, 5);

    // Random flow control on the 8x6 instance, three frames.
    base = n_win8;
    for (int f = 0; f < 3; f++) push_frame(8);
    rnd8 = 1'b1;
    for (int f = 0; f < 3; f++)
      for (int y = 0; y < 6; y++)
        for (int x = 0; x < 8; x++) begin
          int g = 0;
          while ($urandom_range(1, 0) == 1 && g < 8) begin
            v8 = 1'b0; g++;
            @(posedge clk); #1;
          end
          send8(x, y, (x == 0 && y == 0));
        end
    v8 = 1'b0;
    rnd8 = 1'b0;
    @(posedge clk); #2 or8 = 1'b1;
    begin
      int n = 0;
      while (q8.size() != 0 && n < 300) begin @(posedge clk); n++; end
    end
    repeat (4) @(posedge clk);
    #1;
    check_val("t6_drain", 128'(q8.size()), 128'(0));
    check_val("t6_count", 128'(n_win8 - base), 128'(72));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
